// File: rtl/logic_op_pipe.sv
// ---------------------------------------------------------------------------
// logic_op_pipe
//
// Registered, parametrised bitwise logic unit. Each accepted beat either
// produces a result directly from one of eight bitwise functions, or joins
// an accumulate packet that is folded into a single result. Results sit in
// a one-entry output register with valid/ready backpressure.
//
// Parameters
//   WIDTH     operand/result width in bits (>= 1)
//   CNT_W     width of the saturating beat counter (>= 1)
//
// Ports
//   clk       clock, all logic on the rising edge
//   reset     synchronous, active-high reset
//   a, b      operands (b only used on the first beat of a packet)
//   op        0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS_A, 7 NOT_A
//   acc       beat starts or continues an accumulate packet
//   in_valid  input beat valid
//   in_last   last beat of an accumulate packet
//   in_ready  block accepts a beat this cycle
//   c         result
//   c_beats   number of beats folded into c (saturating)
//   c_zero    c == 0
//   c_parity  XOR reduction of c
//   c_valid   result valid
//   c_ready   consumer accepts result
// ---------------------------------------------------------------------------
module logic_op_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             acc,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [WIDTH-1:0] c,
   output logic [CNT_W-1:0] c_beats,
   output logic             c_zero,
   output logic             c_parity,
   output logic             c_valid,
   input  logic             c_ready
);

   typedef enum logic {
      IDLE,
      ACC
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // The eight bitwise functions; PASS_A and NOT_A ignore y.
   function automatic logic [WIDTH-1:0] bit_op(
      input logic [2:0]       sel,
      input logic [WIDTH-1:0] x,
      input logic [WIDTH-1:0] y
   );
      logic [WIDTH-1:0] r;
      case (sel)
         3'd0:    r = x & y;
         3'd1:    r = x | y;
         3'd2:    r = x ^ y;
         3'd3:    r = ~(x & y);
         3'd4:    r = ~(x | y);
         3'd5:    r = ~(x ^ y);
         3'd6:    r = x;
         default: r = ~x;
      endcase
      return r;
   endfunction

   state_t           state, state_n;
   logic [WIDTH-1:0] acc_reg, acc_reg_n;
   logic [2:0]       op_reg, op_reg_n;
   logic [CNT_W-1:0] cnt, cnt_n;

   logic             accept;
   logic             take;
   logic             emit;
   logic [WIDTH-1:0] emit_val;
   logic [CNT_W-1:0] emit_beats;
   logic [WIDTH-1:0] first_val;
   logic [WIDTH-1:0] fold_val;
   logic [CNT_W-1:0] cnt_inc;

   // Ready only when the output register is empty or being drained this
   // cycle, so a new result can always be written without losing one.
   assign in_ready = !reset && (!c_valid || c_ready);
   assign accept   = in_valid && in_ready;
   assign take     = c_valid && c_ready;

   // First beat of anything uses the live op and both operands; later
   // packet beats fold a into the running value with the latched op.
   assign first_val = bit_op(op, a, b);
   assign fold_val  = bit_op(op_reg, acc_reg, a);
   assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

   // Next-state and emission decode.
   always_comb begin
      state_n    = state;
      acc_reg_n  = acc_reg;
      op_reg_n   = op_reg;
      cnt_n      = cnt;
      emit       = 1'b0;
      emit_val   = first_val;
      emit_beats = CNT_ONE;

      case (state)
         IDLE: begin
            if (accept) begin
               if (!acc) begin
                  emit       = 1'b1;
                  emit_val   = first_val;
                  emit_beats = CNT_ONE;
               end else begin
                  acc_reg_n = first_val;
                  op_reg_n  = op;
                  cnt_n     = CNT_ONE;
                  if (in_last) begin
                     emit       = 1'b1;
                     emit_val   = first_val;
                     emit_beats = CNT_ONE;
                  end else begin
                     state_n = ACC;
                  end
               end
            end
         end

         ACC: begin
            if (accept) begin
               acc_reg_n = fold_val;
               cnt_n     = cnt_inc;
               if (in_last) begin
                  emit       = 1'b1;
                  emit_val   = fold_val;
                  emit_beats = cnt_inc;
                  state_n    = IDLE;
               end
            end
         end

         default: state_n = IDLE;
      endcase
   end

   // Packet state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         acc_reg <= '0;
         op_reg  <= 3'd0;
         cnt     <= '0;
      end else begin
         state   <= state_n;
         acc_reg <= acc_reg_n;
         op_reg  <= op_reg_n;
         cnt     <= cnt_n;
      end
   end

   // One-entry output register. A new emission wins over a drain in the
   // same cycle; a plain drain clears valid but leaves c and its flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         c        <= '0;
         c_beats  <= '0;
         c_zero   <= 1'b1;
         c_parity <= 1'b0;
         c_valid  <= 1'b0;
      end else if (emit) begin
         c        <= emit_val;
         c_beats  <= emit_beats;
         c_zero   <= (emit_val == '0);
         c_parity <= ^emit_val;
         c_valid  <= 1'b1;
      end else if (take) begin
         c_valid  <= 1'b0;
      end
   end

endmodule

// File: doc/logic_op_pipe.md
# logic_op_pipe

Registered, parametrised bitwise logic unit: the pipelined, multi-operation successor to the two-input single-gate logic block. Each accepted beat computes one of eight bitwise functions on WIDTH-bit operands, or folds a multi-beat packet into a single result in accumulate mode. Results are held in a one-entry output register with valid/ready backpressure. The block sits between a producer issuing operand beats and a consumer of results.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 8, width of beat counter (≥1)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (first beat of a packet only, in accumulate mode)
- op  in  3  operation select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS_A, 7 NOT_A (ignores b)
- acc  in  1  1 = beat starts or continues an accumulate packet
- in_valid  in  1  input beat valid
- in_last  in  1  last beat of accumulate packet (ignored when acc=0 in IDLE)
- in_ready  out  1  block accepts beat this cycle
- c  out  WIDTH  result
- c_beats  out  CNT_W  beats folded into c, saturating
- c_zero  out  1  c == 0
- c_parity  out  1  XOR reduction of c
- c_valid  out  1  result valid
- c_ready  in  1  consumer accepts result

## Operation
- Beat accepted when in_valid && in_ready. Result taken when c_valid && c_ready.
- in_ready = !reset && (!c_valid || c_ready), identical in all states.
- f(op,x,y) is the bitwise function above. PASS_A returns x; NOT_A returns ~x.
- FSM states: IDLE, ACC.
- IDLE, accepted beat, acc=0: c <= f(op,a,b), c_beats <= 1, c_valid <= 1. Stay IDLE.
- IDLE, accepted beat, acc=1: acc_reg <= f(op,a,b), op_reg <= op, cnt <= 1.
  - If in_last: emit acc_reg value as c with c_beats=1. Stay IDLE.
  - Otherwise: go to ACC.
- ACC, accepted beat: acc_reg <= f(op_reg,acc_reg,a), cnt <= cnt+1, saturating at 2^CNT_W−1.
  - b, op and acc are ignored in ACC.
  - If in_last: emit c, c_beats = updated cnt, c_valid <= 1, go to IDLE.
- No emission occurs for non-last accumulate beats; c and c_valid are unchanged by them.
- c_zero and c_parity are registered alongside c and always consistent with c.
- If a result is taken and a new result is emitted in the same cycle, the new result is loaded and c_valid stays 1.
- If a result is taken with no new emission, c_valid <= 0. c keeps its value.

## Timing
- Reset values: c=0, c_beats=0, c_zero=1, c_parity=0, c_valid=0, FSM=IDLE, acc_reg=0, cnt=0, in_ready=0 while reset is high.
- First cycle after reset deasserts: in_ready=1.
- Latency: non-accumulate result is valid the cycle after acceptance. Accumulate result is valid the cycle after the last beat is accepted.
- Throughput: 1 beat/cycle while c_ready=1.
- Backpressure: while c_valid=1 and c_ready=0, in_ready=0. c and flags are held stable, and no beat is accepted, including mid-packet ACC beats.
- Reset mid-packet: accumulation is abandoned, any held result is discarded, and the FSM returns to IDLE.
- Counter saturation: cnt holds at max. The packet still folds every beat.

## Test plan
- Truth table, WIDTH=8, a=F0, b=CC, op 0..7 back-to-back with c_ready=1 → c = C0, FC, 3C, 3F, 03, C3, F0, 0F, one per cycle, each 1 cycle late. c_beats=1. For XOR, c_parity=0. Then AND a=0F, b=F0 → c=00, c_zero=1.
- Backpressure: hold c_ready=0 after first result (OR 01|02=03), present second beat XOR a=FF, b=0F → in_ready=0, c holds 03 for 5 cycles. Raise c_ready → c=F0 the following cycle.
- Accumulate XOR: acc=1, op=2, beats (a=01, b=02), a=04, a=08 with in_last → single c_valid pulse, c=0F, c_beats=3, c_parity=0.
- Op latch: acc=1, op=AND, a=FF, b=F0; then op=OR (ignored), a=3C, in_last → c=30, c_beats=2.
- Reset mid-packet: two ACC beats, then reset for 1 cycle → c_valid=0, c=00, in_ready=0 during reset. Then non-acc NAND a=FF, b=FF → c=00, c_beats=1.
- Saturation, CNT_W=2: 5-beat OR packet a=01, 02, 04, 08, 10 (b=00) → c=1F, c_beats=3.
